logic_sweep_sequencer: RTL and testbench



---
 rtl/lu_pkg.sv | 19 +
 rtl/logic_sweep_sequencer_if.sv | 30 +++
 rtl/lu_golden.sv | 12 +
 rtl/logic_sweep_sequencer.sv | 99 +++++++++
 tb/tb_logic_sweep_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit sweep sequencer: state encoding,
// the golden truth table and the bit positions of the minterm index.
package lu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit m is the expected unit output for minterm m = {sel1, sel2, a, b}.
  localparam logic [15:0] LU_GOLDEN_TABLE = 16'h17E8;

  localparam int SEL1_BIT = 3;
  localparam int SEL2_BIT = 2;
  localparam int A_BIT    = 1;
  localparam int B_BIT    = 0;

endpackage

// File: rtl/logic_sweep_sequencer_if.sv
// Bundle between the sweep sequencer and its environment (logic unit + host).
// The master side is the sequencer itself.
interface logic_sweep_sequencer_if;

  logic        start;
  logic        s_in;
  logic        a_out;
  logic        b_out;
  logic        sel1_out;
  logic        sel2_out;
  logic [3:0]  m;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic        err;
  logic [4:0]  err_count;

  modport master (
    input  start, s_in,
    output a_out, b_out, sel1_out, sel2_out, m,
           busy, done, table_out, err, err_count
  );

  modport slave (
    output start, s_in,
    input  a_out, b_out, sel1_out, sel2_out, m,
           busy, done, table_out, err, err_count
  );

endinterface

// File: rtl/lu_golden.sv
// Reference model of the selectable AND/OR/NAND/NOR unit: expected output
// bit for a given minterm index.
module lu_golden
  import lu_pkg::*;
(
  input  logic [3:0] m_i,
  output logic       expected_o
);

  assign expected_o = LU_GOLDEN_TABLE[m_i];

endmodule

// File: rtl/logic_sweep_sequencer.sv
// Steps the logic unit through all 16 minterms, samples its result after
// SETTLE cycles per vector and checks the captured table against the golden one.
module logic_sweep_sequencer
  import lu_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  logic_sweep_sequencer_if.master  bus
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e      state_q;
  logic [3:0]  m_q;
  logic [3:0]  wait_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] table_q;
  logic        err_q;
  logic [4:0]  err_count_q;
  logic        expected;

  lu_golden u_golden (
    .m_i        (m_q),
    .expected_o (expected)
  );

  // Sampling happens on the last settle cycle of each vector; the table,
  // error flag and count survive until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      m_q         <= 4'd0;
      wait_q      <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      table_q     <= 16'h0000;
      err_q       <= 1'b0;
      err_count_q <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            m_q         <= 4'd0;
            wait_q      <= 4'd0;
            table_q     <= 16'h0000;
            err_q       <= 1'b0;
            err_count_q <= 5'd0;
          end
        end
        RUN: begin
          if (wait_q == SETTLE_LAST) begin
            table_q[m_q] <= bus.s_in;
            if (bus.s_in != expected) begin
              err_q       <= 1'b1;
              err_count_q <= err_count_q + 5'd1;
            end
            wait_q <= 4'd0;
            if (m_q == 4'd15) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              m_q <= m_q + 4'd1;
            end
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          m_q     <= 4'd0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m         = m_q;
  assign bus.sel1_out  = m_q[SEL1_BIT];
  assign bus.sel2_out  = m_q[SEL2_BIT];
  assign bus.a_out     = m_q[A_BIT];
  assign bus.b_out     = m_q[B_BIT];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.table_out = table_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_logic_sweep_sequencer.sv
// Scoreboard bench for logic_sweep_sequencer: two instances (SETTLE=1 and 3),
// each driving a behavioural logic unit whose behaviour can be faulted.
module tb_logic_sweep_sequencer;

  typedef struct {
    logic [15:0] tbl;
    logic        err;
    logic [4:0]  cnt;
    int          doneCyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mode1 = 0;
  int   mode3 = 0;
  int   doneCount1 = 0;
  int   doneCount3 = 0;
  exp_t q1[$];
  exp_t q3[$];

  logic_sweep_sequencer_if bus1();
  logic_sweep_sequencer_if bus3();

  logic_sweep_sequencer #(.SETTLE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  logic_sweep_sequencer #(.SETTLE(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural logic unit: 0 real, 1 stuck-at-0, 2 stuck-at-1, 3 NAND/NOR swapped.
  function automatic logic unitModel(int mode, logic s1, logic s2, logic a, logic b);
    logic r;
    case ({s1, s2})
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = (mode == 3) ? ~(a | b) : ~(a & b);
      default: r = (mode == 3) ? ~(a & b) : ~(a | b);
    endcase
    if (mode == 1) r = 1'b0;
    if (mode == 2) r = 1'b1;
    return r;
  endfunction

  assign bus1.s_in = unitModel(mode1, bus1.sel1_out, bus1.sel2_out, bus1.a_out, bus1.b_out);
  assign bus3.s_in = unitModel(mode3, bus3.sel1_out, bus3.sel2_out, bus3.a_out, bus3.b_out);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors pop one expected sweep result for every done pulse seen.
  always @(negedge clk) begin
    if (!reset && bus1.done === 1'b1) begin
      exp_t e;
      doneCount1++;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone1: got done at cycle %0d, expected no done", cyc);
      end else begin
        e = q1.pop_front();
        checkOutput("table1", 32'(bus1.table_out), 32'(e.tbl));
        checkOutput("err1", 32'(bus1.err), 32'(e.err));
        checkOutput("errCount1", 32'(bus1.err_count), 32'(e.cnt));
        checkOutput("doneCycle1", 32'(cyc), 32'(e.doneCyc));
        checkOutput("busyAtDone1", 32'(bus1.busy), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus3.done === 1'b1) begin
      exp_t e;
      doneCount3++;
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone3: got done at cycle %0d, expected no done", cyc);
      end else begin
        e = q3.pop_front();
        checkOutput("table3", 32'(bus3.table_out), 32'(e.tbl));
        checkOutput("err3", 32'(bus3.err), 32'(e.err));
        checkOutput("errCount3", 32'(bus3.err_count), 32'(e.cnt));
        checkOutput("doneCycle3", 32'(cyc), 32'(e.doneCyc));
      end
    end
  end

  // Pulses start for one cycle and records the hand-computed sweep result.
  task automatic applyStimulus(input int which, input int mode, input logic [15:0] tbl,
                               input logic e, input logic [4:0] cnt);
    exp_t x;
    @(negedge clk);
    x.tbl = tbl;
    x.err = e;
    x.cnt = cnt;
    if (which == 1) begin
      mode1 = mode;
      x.doneCyc = cyc + 1 + 16;
      q1.push_back(x);
      bus1.start = 1'b1;
    end else begin
      mode3 = mode;
      x.doneCyc = cyc + 1 + 48;
      q3.push_back(x);
      bus3.start = 1'b1;
    end
    @(negedge clk);
    bus1.start = 1'b0;
    bus3.start = 1'b0;
  endtask

  task automatic waitDone(input int which, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 1 && bus1.done === 1'b1) || (which == 3 && bus3.done === 1'b1)) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneTimeout%0d: got no done within %0d cycles, expected done", which, budget);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_m"}, 32'(bus1.m), 32'd0);
    checkOutput({tag, "_vec"}, 32'({bus1.sel1_out, bus1.sel2_out, bus1.a_out, bus1.b_out}), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus1.busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(bus1.done), 32'd0);
    checkOutput({tag, "_table"}, 32'(bus1.table_out), 32'd0);
    checkOutput({tag, "_err"}, 32'(bus1.err), 32'd0);
    checkOutput({tag, "_errCount"}, 32'(bus1.err_count), 32'd0);
  endtask

  initial begin
    int base;
    exp_t x;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    checkOutput("reset3_busy", 32'(bus3.busy), 32'd0);
    reset = 1'b0;

    $display("[TB] sweep with real unit, SETTLE=1");
    applyStimulus(1, 0, 16'h17E8, 1'b0, 5'd0);
    checkOutput("busyAfterStart", 32'(bus1.busy), 32'd1);
    waitDone(1, 40);

    $display("[TB] unit output stuck at 0 and at 1");
    applyStimulus(1, 1, 16'h0000, 1'b1, 5'd8);
    waitDone(1, 40);
    applyStimulus(1, 2, 16'hFFFF, 1'b1, 5'd8);
    waitDone(1, 40);

    $display("[TB] SETTLE=3 sweep");
    applyStimulus(3, 0, 16'h17E8, 1'b0, 5'd0);
    for (int k = 0; k < 48; k++) begin
      checkOutput("m3Step", 32'(bus3.m), 32'(k / 3));
      @(negedge clk);
    end
    checkOutput("done3AtEnd", 32'(bus3.done), 32'd1);
    repeat (3) @(negedge clk);

    $display("[TB] start pulses while busy");
    base = doneCount1;
    applyStimulus(1, 0, 16'h17E8, 1'b0, 5'd0);
    repeat (3) @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (4) @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    waitDone(1, 40);
    repeat (30) @(negedge clk);
    checkOutput("singleDone", 32'(doneCount1 - base), 32'd1);
    checkOutput("idleAfterIgnoredStart", 32'(bus1.busy), 32'd0);

    $display("[TB] asynchronous reset mid-sweep");
    applyStimulus(1, 0, 16'h17E8, 1'b0, 5'd0);
    for (int i = 0; i < 20; i++) begin
      if (bus1.m == 4'd6) break;
      @(negedge clk);
    end
    checkOutput("reachM6", 32'(bus1.m), 32'd6);
    #2;
    reset = 1'b1;
    q1.delete();
    #1;
    checkAllZero("midReset");
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 0, 16'h17E8, 1'b0, 5'd0);
    checkOutput("restartM0", 32'(bus1.m), 32'd0);
    waitDone(1, 40);

    $display("[TB] start held across two sweeps, NAND/NOR swapped on second");
    @(negedge clk);
    mode1 = 0;
    x.tbl = 16'h17E8; x.err = 1'b0; x.cnt = 5'd0; x.doneCyc = cyc + 1 + 16;
    q1.push_back(x);
    x.tbl = 16'h71E8; x.err = 1'b1; x.cnt = 5'd4; x.doneCyc = cyc + 1 + 16 + 18;
    q1.push_back(x);
    bus1.start = 1'b1;
    waitDone(1, 40);
    mode1 = 3;
    repeat (2) @(negedge clk);
    checkOutput("tableClearedOnRestart", 32'(bus1.table_out), 32'd0);
    checkOutput("errClearedOnRestart", 32'(bus1.err), 32'd0);
    checkOutput("busyOnRestart", 32'(bus1.busy), 32'd1);
    waitDone(1, 40);
    bus1.start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idleAfterHeld", 32'(bus1.busy), 32'd0);

    checkOutput("queue1Drained", 32'(q1.size()), 32'd0);
    checkOutput("queue3Drained", 32'(q3.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
